// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects ALU or memory result, commits it to an 8x16 register file, serves two
// decode read ports and tracks in-flight writes per register to raise Stall on hazards (WB_BYPASS_EN).
module wb_regfile_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MTRIn,
  input  logic              RWIn,
  input  logic [ADDR_W-1:0] RegDestIn,
  input  logic [DATA_W-1:0] aluOutIn,
  input  logic [DATA_W-1:0] memDataIn,
  input  logic              IssueValid,
  input  logic              IssueRW,
  input  logic [ADDR_W-1:0] IssueDest,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  input  logic              ReadUse1,
  input  logic              ReadUse2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] wbData,
  output logic              Stall,
  output logic              ScoreErr
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              err_q;
  logic              err_d;
  logic [DATA_W-1:0] wb_data_s;
  logic              pend1_s;
  logic              pend2_s;
  logic              sat_s;
  logic              stall_s;
  logic              issue_s;

  // Write-back value select and read ports
  always_comb begin
    wb_data_s = MTRIn ? memDataIn : aluOutIn;
`ifdef WB_BYPASS_EN
    if (RWIn && (RegDestIn == ReadAddr1)) begin
      ReadData1 = wb_data_s;
    end else begin
      ReadData1 = regs_q[ReadAddr1];
    end
    if (RWIn && (RegDestIn == ReadAddr2)) begin
      ReadData2 = wb_data_s;
    end else begin
      ReadData2 = regs_q[ReadAddr2];
    end
`else
    ReadData1 = regs_q[ReadAddr1];
    ReadData2 = regs_q[ReadAddr2];
`endif
  end

  // Hazard detection: a source is pending while writes are in flight to it
  always_comb begin
`ifdef WB_BYPASS_EN
    // The last outstanding write retiring right now is forwarded, so it no longer blocks
    pend1_s = (cnt_q[ReadAddr1] != CNT_ZERO) &&
              !((cnt_q[ReadAddr1] == CNT_ONE) && RWIn && (RegDestIn == ReadAddr1));
    pend2_s = (cnt_q[ReadAddr2] != CNT_ZERO) &&
              !((cnt_q[ReadAddr2] == CNT_ONE) && RWIn && (RegDestIn == ReadAddr2));
`else
    pend1_s = (cnt_q[ReadAddr1] != CNT_ZERO);
    pend2_s = (cnt_q[ReadAddr2] != CNT_ZERO);
`endif
    sat_s   = IssueRW && (cnt_q[IssueDest] == CNT_MAX) &&
              !(RWIn && (RegDestIn == IssueDest));
    stall_s = IssueValid && ((ReadUse1 && pend1_s) || (ReadUse2 && pend2_s) || sat_s);
    issue_s = IssueValid && IssueRW && !stall_s;
  end

  // Scoreboard next state: issue increments, retire decrements, both on one register cancel
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      case ({issue_s && (IssueDest == ADDR_W'(r)), RWIn && (RegDestIn == ADDR_W'(r))})
        2'b10: cnt_d[r] = cnt_q[r] + CNT_ONE;
        2'b01: begin
          if (cnt_q[r] == CNT_ZERO) begin
            err_d = 1'b1;
          end else begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
          end
        end
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Register file, scoreboard and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= {DATA_W{1'b0}};
        cnt_q[r]  <= CNT_ZERO;
      end
      err_q <= 1'b0;
    end else begin
      if (RWIn) begin
        regs_q[RegDestIn] <= wb_data_s;
      end
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign wbData   = wb_data_s;
  assign Stall    = stall_s;
  assign ScoreErr = err_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: expected values are queued as stimulus is driven and popped
// at each sample point. Honours WB_BYPASS_EN for the forwarding-dependent expectations.
module tb_wb_regfile_stage;

  logic        clk;
  logic        rst;
  logic        MTRIn;
  logic        RWIn;
  logic [2:0]  RegDestIn;
  logic [15:0] aluOutIn;
  logic [15:0] memDataIn;
  logic        IssueValid;
  logic        IssueRW;
  logic [2:0]  IssueDest;
  logic [2:0]  ReadAddr1;
  logic [2:0]  ReadAddr2;
  logic        ReadUse1;
  logic        ReadUse2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [15:0] wbData;
  logic        Stall;
  logic        ScoreErr;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          passes;
  logic [15:0] vals [8];

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .MTRIn(MTRIn), .RWIn(RWIn), .RegDestIn(RegDestIn),
    .aluOutIn(aluOutIn), .memDataIn(memDataIn), .IssueValid(IssueValid), .IssueRW(IssueRW),
    .IssueDest(IssueDest), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .ReadUse1(ReadUse1),
    .ReadUse2(ReadUse2), .ReadData1(ReadData1), .ReadData2(ReadData2), .wbData(wbData),
    .Stall(Stall), .ScoreErr(ScoreErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passes++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // Advance to the next falling edge (passing one rising edge) and clear the per-cycle controls
  task automatic next_cycle();
    @(negedge clk);
    rst        = 1'b0;
    RWIn       = 1'b0;
    MTRIn      = 1'b0;
    IssueValid = 1'b0;
    IssueRW    = 1'b0;
    ReadUse1   = 1'b0;
    ReadUse2   = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1; MTRIn = 1'b0; RWIn = 1'b0; RegDestIn = 3'd0; aluOutIn = 16'h0000;
    memDataIn = 16'h0000; IssueValid = 1'b0; IssueRW = 1'b0; IssueDest = 3'd0;
    ReadAddr1 = 3'd0; ReadAddr2 = 3'd7; ReadUse1 = 1'b0; ReadUse2 = 1'b0;

    // Reset state
    next_cycle();
    #1;
    push("rst_rd1", 16'h0000); chk(ReadData1);
    push("rst_rd2", 16'h0000); chk(ReadData2);
    push("rst_stall", 16'h0000); chk({15'd0, Stall});
    push("rst_err", 16'h0000); chk({15'd0, ScoreErr});

    // ALU write-back to r3, visible next cycle
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd3;
    #1; push("t1_issue_stall", 16'h0000); chk({15'd0, Stall});
    next_cycle();
    RWIn = 1'b1; MTRIn = 1'b0; RegDestIn = 3'd3; aluOutIn = 16'h1234;
    #1; push("t1_wbdata", 16'h1234); chk(wbData);
    next_cycle();
    ReadAddr1 = 3'd3;
    #1; push("t1_read", 16'h1234); chk(ReadData1);
    push("t1_err", 16'h0000); chk({15'd0, ScoreErr});

    // Memory write-back to r5
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd5;
    next_cycle();
    RWIn = 1'b1; MTRIn = 1'b1; memDataIn = 16'hBEEF; aluOutIn = 16'h0001; RegDestIn = 3'd5;
    #1; push("t2_wbdata", 16'hBEEF); chk(wbData);
    next_cycle();
    ReadAddr2 = 3'd5;
    #1; push("t2_read", 16'hBEEF); chk(ReadData2);

    // RAW hazard on r2
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd2;
    next_cycle();
    IssueValid = 1'b1; ReadAddr1 = 3'd2; ReadUse1 = 1'b1;
    #1; push("t3_hazard", 16'h0001); chk({15'd0, Stall});
    next_cycle();
    IssueValid = 1'b1; ReadAddr1 = 3'd2; ReadUse1 = 1'b1;
    RWIn = 1'b1; RegDestIn = 3'd2; aluOutIn = 16'h0A0A;
    #1;
`ifdef WB_BYPASS_EN
    push("t3_retire_stall", 16'h0000); push("t3_retire_rd1", 16'h0A0A);
`else
    push("t3_retire_stall", 16'h0001); push("t3_retire_rd1", 16'h0000);
`endif
    chk({15'd0, Stall}); chk(ReadData1);
    next_cycle();
    IssueValid = 1'b1; ReadAddr1 = 3'd2; ReadUse1 = 1'b1;
    #1; push("t3_after_stall", 16'h0000); chk({15'd0, Stall});
    push("t3_after_rd1", 16'h0A0A); chk(ReadData1);

    // Saturate the r4 counter
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd4;
    end
    next_cycle();
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd4;
    #1; push("t4_sat_stall", 16'h0001); chk({15'd0, Stall});
    next_cycle();
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd4;
    RWIn = 1'b1; RegDestIn = 3'd4; aluOutIn = 16'h4444;
    #1; push("t4_sat_retire", 16'h0000); chk({15'd0, Stall});
    next_cycle();
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd4;
    #1; push("t4_still_full", 16'h0001); chk({15'd0, Stall});
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      RWIn = 1'b1; RegDestIn = 3'd4; aluOutIn = 16'h4440 + 16'(i);
    end
    next_cycle();
    IssueValid = 1'b1; ReadAddr1 = 3'd4; ReadUse1 = 1'b1;
    #1; push("t4_drained_stall", 16'h0000); chk({15'd0, Stall});
    push("t4_drained_err", 16'h0000); chk({15'd0, ScoreErr});
    push("t4_last_value", 16'h4442); chk(ReadData1);

    // Pipelined issue/retire across all registers with random data
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      if (k < 8) begin
        IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'(k);
        vals[k] = 16'($urandom);
      end
      if (k > 0) begin
        RWIn = 1'b1; RegDestIn = 3'(k - 1); aluOutIn = vals[k - 1];
      end
    end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      ReadAddr1 = 3'(k); ReadAddr2 = 3'(7 - k);
      #1; push("sweep_rd1", vals[k]); chk(ReadData1);
      push("sweep_rd2", vals[7 - k]); chk(ReadData2);
    end
    push("sweep_err", 16'h0000); chk({15'd0, ScoreErr});

    // Retire with no pending write on r6
    next_cycle();
    RWIn = 1'b1; RegDestIn = 3'd6; aluOutIn = 16'h6666;
    next_cycle();
    ReadAddr1 = 3'd6;
    #1; push("t5_err_set", 16'h0001); chk({15'd0, ScoreErr});
    push("t5_written", 16'h6666); chk(ReadData1);
    next_cycle();
    #1; push("t5_err_sticky", 16'h0001); chk({15'd0, ScoreErr});

    // Mid-stream reset with pending writes and a concurrent write-back
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd1;
    next_cycle();
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd1;
    next_cycle();
    rst = 1'b1; RWIn = 1'b1; RegDestIn = 3'd1; aluOutIn = 16'h1111;
    IssueValid = 1'b1; IssueRW = 1'b1; IssueDest = 3'd1;
    next_cycle();
    IssueValid = 1'b1; ReadAddr1 = 3'd1; ReadUse1 = 1'b1; ReadAddr2 = 3'd5;
    #1; push("t6_rd1", 16'h0000); chk(ReadData1);
    push("t6_rd2", 16'h0000); chk(ReadData2);
    push("t6_stall", 16'h0000); chk({15'd0, Stall});
    push("t6_err", 16'h0000); chk({15'd0, ScoreErr});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
